// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the video-RAM arbiter.
// The optional write-starvation guard is enabled with VRAM_ARB_WR_GUARD_EN.
package vram_arb_pkg;

    localparam int ADDR_W_DEF       = 19;
    localparam int DATA_W_DEF       = 3;
    localparam int STARVE_LIMIT_DEF = 8;

    // Memory-cycle type issued to the RAM in the current cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } mem_op_e;

endpackage

// File: rtl/vram_wr_buffer.sv
// One-entry write holding register between the pixel writer and the RAM arbiter.
// Handshake: a write transfers on a rising edge where i_wr_valid & o_ready; o_ready comes only from registered state.
module vram_wr_buffer #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_drain,
    output logic              o_ready,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic              r_live;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Load only when empty and drain only when full, so the two never coincide.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_live <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_live <= 1'b1;
            if (i_wr_valid && o_ready) begin
                r_full <= 1'b1;
                r_addr <= i_wr_addr;
                r_data <= i_wr_data;
            end else if (i_drain) begin
                r_full <= 1'b0;
            end
        end
    end

    // r_live keeps ready low while reset is held and for the reset edge itself.
    assign o_ready = r_live && !r_full;
    assign o_full  = r_full;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: display reads have fixed priority, writes drain from a one-entry buffer.
// Define VRAM_ARB_WR_GUARD_EN to build the write-starvation guard (forces a write after STARVE_LIMIT losses).
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iDispReq,
    input  logic [ADDR_W-1:0] iDispAddr,
    output logic [DATA_W-1:0] oDispData,
    output logic              oDispValid,
    output logic              oDispMiss,
    input  logic              iWrValid,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    output logic              oWrReady,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWe,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    output mem_op_e           oDbgState
);

    logic              w_buf_full;
    logic [ADDR_W-1:0] w_buf_addr;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_fire;
    logic              w_do_rd;
    logic              w_do_wr;

    mem_op_e           r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_rd_pipe;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;

    vram_wr_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_buffer (
        .i_clk      (Clock),
        .i_rst_n    (Reset),
        .i_wr_valid (iWrValid),
        .i_wr_addr  (iWrAddr),
        .i_wr_data  (iWrData),
        .i_drain    (w_do_wr),
        .o_ready    (oWrReady),
        .o_full     (w_buf_full),
        .o_addr     (w_buf_addr),
        .o_data     (w_buf_data)
    );

`ifdef VRAM_ARB_WR_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [1:0]       r_miss_pipe;
    logic             r_disp_miss;

    assign w_fire = w_buf_full && (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts cycles the held write loses to the display; a forced write drops that cycle's read.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_starve_cnt <= '0;
            r_miss_pipe  <= 2'b00;
            r_disp_miss  <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_starve_cnt <= '0;
            end else if (w_buf_full && w_do_rd) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            r_miss_pipe <= {r_miss_pipe[0], w_fire && iDispReq};
            r_disp_miss <= r_miss_pipe[1];
        end
    end

    assign oDispMiss = r_disp_miss;
`else
    logic w_unused_limit;

    assign w_unused_limit = |STARVE_LIMIT;
    assign w_fire         = 1'b0;
    assign oDispMiss      = 1'b0;
`endif

    assign w_do_rd = iDispReq && !w_fire;
    assign w_do_wr = !w_do_rd && w_buf_full;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else if (w_do_rd) begin
            r_state    <= RD;
            r_mem_addr <= iDispAddr;
            r_mem_we   <= 1'b0;
        end else if (w_do_wr) begin
            r_state     <= WR;
            r_mem_addr  <= w_buf_addr;
            r_mem_wdata <= w_buf_data;
            r_mem_we    <= 1'b1;
        end else begin
            r_state  <= IDLE;
            r_mem_we <= 1'b0;
        end
    end

    // RAM data appears one cycle after the address; stage 2 marks that data for capture.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_rd_pipe    <= 2'b00;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_rd_pipe    <= {r_rd_pipe[0], w_do_rd};
            r_disp_valid <= r_rd_pipe[1];
            if (r_rd_pipe[1]) begin
                r_disp_data <= iMemRData;
            end
        end
    end

    assign oMemAddr   = r_mem_addr;
    assign oMemWe     = r_mem_we;
    assign oMemWData  = r_mem_wdata;
    assign oDispValid = r_disp_valid;
    assign oDispData  = r_disp_data;
    assign oDbgState  = r_state;

endmodule
